// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, constants and packet helpers for the bus arbiter
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } bus_state_e;

  // Destination ID lives in the top ID_W bits of a pkt_sz-wide packet
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                              input int pkt_sz);
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_sz - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant of the first request at or after a pointer
module rr_arbiter #(
  parameter int drvrs = 4,
  localparam int PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic [drvrs-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [drvrs-1:0] grant,
  output logic             valid
);

  logic [2*drvrs-1:0] dbl_req;
  logic [2*drvrs-1:0] dbl_gnt;
  logic [drvrs-1:0]   rot_req;
  logic [drvrs-1:0]   rot_gnt;

  // Rotate so the pointer sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[drvrs-1:0];
    rot_gnt = rot_req & (-rot_req);
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    grant   = dbl_gnt[2*drvrs-1:drvrs];
    valid   = |req;
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// rtl/bus_generator_arbiter.sv - per-bus round-robin arbiter moving packets between device FIFOs
module bus_generator_arbiter
  import bus_pkg::*;
#(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [bits-1:0][drvrs-1:0]               pndng,
  output logic [bits-1:0][drvrs-1:0]               push,
  output logic [bits-1:0][drvrs-1:0]               pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

  localparam int PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [drvrs-1:0]   grant;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [ID_W-1:0]    id;
    logic [drvrs-1:0]   pop_vec;
    logic [drvrs-1:0]   push_vec;

    rr_arbiter #(.drvrs(drvrs)) u_arb (
      .req   (pndng[b]),
      .ptr   (ptr_q),
      .grant (grant),
      .valid (grant_vld)
    );

    // Encode the one-hot grant into the winner index
    always_comb begin
      grant_idx = '0;
      for (int i = 0; i < drvrs; i++) begin
        if (grant[i]) grant_idx = PTR_W'(i);
      end
    end

    // IDLE -> POP -> PUSH -> IDLE; winner, pointer and packet captured along the way
    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      pkt_d   = pkt_q;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            win_d   = grant_idx;
            state_d = ST_POP;
          end
        end
        ST_POP: begin
          pkt_d   = D_pop[b][win_q];
          ptr_d   = (win_q == PTR_W'(drvrs - 1)) ? '0 : win_q + PTR_W'(1);
          state_d = ST_PUSH;
        end
        ST_PUSH: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // State registers; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        ptr_q   <= '0;
        win_q   <= '0;
        pkt_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        win_q   <= win_d;
        pkt_q   <= pkt_d;
      end
    end

    // Strobe decode: pop the winner in POP, deliver by destination ID in PUSH
    always_comb begin
      pop_vec  = '0;
      push_vec = '0;
      id       = dest_id(MAX_PKT_W'(pkt_q), pckg_sz);
      if (state_q == ST_POP) pop_vec[win_q] = 1'b1;
      if (state_q == ST_PUSH) begin
        for (int d = 0; d < drvrs; d++) begin
          if (id == broadcast) begin
            push_vec[d] = (PTR_W'(d) != win_q);
          end else if (id == ID_W'(d)) begin
            push_vec[d] = 1'b1;
          end
        end
      end
    end

    assign pop[b]    = pop_vec;
    assign push[b]   = push_vec;
    assign D_push[b] = {drvrs{pkt_q}};
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// tb/tb_bus_generator_arbiter.sv - self-checking bench for bus_generator_arbiter
module tb_bus_generator_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [0:0][3:0]       pndng = '0;
  logic [0:0][3:0]       push;
  logic [0:0][3:0]       pop;
  logic [0:0][3:0][15:0] D_pop = '0;
  logic [0:0][3:0][15:0] D_push;

  bus_generator_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .push   (push),
    .pop    (pop),
    .D_pop  (D_pop),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] fifo [4][$];
  int  rr_ptr = 0;
  int  next_idle = 0;
  bit  in_rst = 1'b0;
  logic [3:0]  exp_pop  [int];
  logic [3:0]  exp_push [int];
  logic [15:0] exp_data [int];
  int          rm_at    [int];
  logic [15:0] cur_dpush = '0;
  int exp_bits = 0;
  int obs_bits = 0;

  int          pop_src [$];
  int          pop_cyc [$];
  logic [3:0]  push_vl [$];
  logic [15:0] push_dl [$];
  int          push_cyc [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] targets(input int src, input logic [15:0] p);
    logic [7:0] id;
    id = p[15:8];
    if (id == 8'hFF)   return 4'hF & ~(4'b0001 << src);
    else if (id < 8'd4) return 4'b0001 << id;
    else               return 4'b0000;
  endfunction

  // One clock cycle: check this cycle's outputs, advance the model, drive the FIFO heads
  task automatic step();
    logic [3:0]  e_pop;
    logic [3:0]  e_push;
    int          w;
    logic [3:0]  t;
    @(negedge clk);
    cyc++;
    e_pop  = exp_pop.exists(cyc)  ? exp_pop[cyc]  : 4'b0;
    e_push = exp_push.exists(cyc) ? exp_push[cyc] : 4'b0;
    if (exp_data.exists(cyc)) cur_dpush = exp_data[cyc];
    exp_bits += $countones(e_push);
    chk("pop", 64'(pop[0]), 64'(e_pop));
    chk("push", 64'(push[0]), 64'(e_push));
    chk("D_push", D_push[0], {4{cur_dpush}});
    for (int d = 0; d < 4; d++) begin
      if (pop[0][d]) begin
        pop_src.push_back(d);
        pop_cyc.push_back(cyc);
      end
    end
    if (push[0] != 4'b0) begin
      push_vl.push_back(push[0]);
      push_dl.push_back(D_push[0][0]);
      push_cyc.push_back(cyc);
    end
    obs_bits += $countones(push[0]);
    if (rm_at.exists(cyc)) void'(fifo[rm_at[cyc]].pop_front());
    if (!in_rst && cyc >= next_idle) begin
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && fifo[(rr_ptr + i) % 4].size() > 0) w = (rr_ptr + i) % 4;
      end
      if (w >= 0) begin
        t = targets(w, fifo[w][0]);
        exp_pop[cyc+1]  = 4'b0001 << w;
        exp_push[cyc+2] = t;
        exp_data[cyc+2] = fifo[w][0];
        rm_at[cyc+2]    = w;
        rr_ptr          = (w + 1) % 4;
        next_idle       = cyc + 3;
      end
    end
    for (int d = 0; d < 4; d++) begin
      pndng[0][d] = (fifo[d].size() > 0);
      D_pop[0][d] = (fifo[d].size() > 0) ? fifo[d][0] : 16'h0;
    end
  endtask

  initial begin
    int s_pop;
    int s_push;
    int src;
    int sel;
    logic [7:0] dst;
    bit found;

    // Reset
    in_rst = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_pop", 64'(pop[0]), 64'h0);
    chk("rst_push", 64'(push[0]), 64'h0);
    chk("rst_dpush", D_push[0], 64'h0);
    repeat (2) step();
    reset = 1'b0;
    in_rst = 1'b0;
    next_idle = cyc + 1;
    step();

    // Unicast 1 -> 2
    s_pop = pop_src.size();
    s_push = push_vl.size();
    fifo[1].push_back(16'h0234);
    repeat (5) step();
    chk("uni_pop_src", 64'(pop_src[s_pop]), 64'd1);
    chk("uni_pop_cnt", 64'(pop_src.size() - s_pop), 64'd1);
    chk("uni_push_vec", 64'(push_vl[s_push]), 64'h4);
    chk("uni_push_dat", 64'(push_dl[s_push]), 64'h0234);
    chk("uni_latency", 64'(push_cyc[s_push] - pop_cyc[s_pop]), 64'd1);

    // Broadcast from 0
    s_push = push_vl.size();
    fifo[0].push_back(16'hFF5A);
    repeat (5) step();
    chk("bc_push_vec", 64'(push_vl[s_push]), 64'hE);
    chk("bc_push_dat", 64'(push_dl[s_push]), 64'hFF5A);
    chk("bc_push_cnt", 64'(push_vl.size() - s_push), 64'd1);

    // Reset during POP
    fifo[2].push_back(16'h0155);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (pop[0] != 4'b0) found = 1'b1;
    end
    chk("midpop_seen", 64'(found), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midpop_rst_pop", 64'(pop[0]), 64'h0);
    chk("midpop_rst_push", 64'(push[0]), 64'h0);
    chk("midpop_rst_dpush", D_push[0], 64'h0);
    in_rst = 1'b1;
    for (int d = 0; d < 4; d++) fifo[d].delete();
    exp_pop.delete();
    exp_push.delete();
    exp_data.delete();
    rm_at.delete();
    rr_ptr = 0;
    cur_dpush = '0;
    step();
    reset = 1'b0;
    in_rst = 1'b0;
    next_idle = cyc + 1;
    repeat (4) step();

    // Round-robin with 0, 2, 3 pending
    s_pop = pop_src.size();
    for (int k = 0; k < 2; k++) begin
      fifo[0].push_back(16'h0110 + 16'(k));
      fifo[2].push_back(16'h0320 + 16'(k));
      fifo[3].push_back(16'h0030 + 16'(k));
    end
    repeat (24) step();
    chk("rr_count", 64'(pop_src.size() - s_pop), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", 64'(pop_src[s_pop + k]), 64'((k % 3 == 0) ? 0 : (k % 3 == 1) ? 2 : 3));
    end
    for (int k = 1; k < 6; k++) begin
      chk("rr_spacing", 64'(pop_cyc[s_pop + k] - pop_cyc[s_pop + k - 1]), 64'd3);
    end

    // Invalid ID from 3, then a normal transfer from 0
    s_pop = pop_src.size();
    s_push = push_vl.size();
    fifo[3].push_back(16'h0711);
    repeat (2) step();
    fifo[0].push_back(16'h0322);
    repeat (8) step();
    chk("inv_pop_src", 64'(pop_src[s_pop]), 64'd3);
    chk("inv_next_src", 64'(pop_src[s_pop + 1]), 64'd0);
    chk("inv_push_cnt", 64'(push_vl.size() - s_push), 64'd1);
    chk("inv_next_vec", 64'(push_vl[s_push]), 64'h8);
    chk("inv_next_dat", 64'(push_dl[s_push]), 64'h0322);
    chk("inv_next_lat", 64'(push_cyc[s_push] - pop_cyc[s_pop + 1]), 64'd1);

    // Random traffic
    for (int n = 0; n < 8; n++) begin
      src = $urandom_range(0, 3);
      sel = $urandom_range(0, 4);
      dst = (sel == 4) ? 8'hFF : 8'(sel);
      fifo[src].push_back({dst, 8'($urandom)});
      repeat ($urandom_range(0, 4)) step();
    end
    repeat (40) step();
    for (int d = 0; d < 4; d++) chk("rand_drained", 64'(fifo[d].size()), 64'd0);
    chk("total_deliveries", 64'(obs_bits), 64'(exp_bits));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
